// File: rtl/bcd_rtc_sec.sv
// 24-h BCD real-time clock with prescaler, validated load and 12/24-h display.
// Optional alarm enabled by defining BCD_RTC_ALARM_EN.
module bcd_rtc_sec #(
  parameter int unsigned TICK_DIV = 1,
  parameter logic [7:0]  RST_HH   = 8'h00
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ena_i,
  input  logic       mode_24h_i,
  input  logic       load_i,
  input  logic [7:0] load_hh_i,
  input  logic [7:0] load_mm_i,
  input  logic [7:0] load_ss_i,
  output logic [7:0] hh_o,
  output logic [7:0] mm_o,
  output logic [7:0] ss_o,
  output logic       pm_o,
  output logic       day_tick_o,
  output logic       load_err_o,
  input  logic       alarm_set_i,
  input  logic [7:0] alarm_hh_i,
  input  logic [7:0] alarm_mm_i,
  input  logic       alarm_ack_i,
  output logic       alarm_ring_o
);

  localparam logic [15:0] PRE_TOP = 16'(TICK_DIV - 1);

  logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [15:0] pre_q, pre_d;
  logic        day_q, day_d, err_q, err_d;
  logic        sec_tick, load_ok;

  function automatic logic bcd_ok(
    input logic [7:0] v,
    input logic [7:0] max
  );
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9)
        && (v <= max);
  endfunction

  function automatic logic [7:0] inc60(
    input logic [7:0] v
  );
    if (v[3:0] != 4'd9)
      return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] == 4'd5)
      return 8'h00;
    return {v[7:4] + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] inc24(
    input logic [7:0] v
  );
    if (v == 8'h23)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign sec_tick = ena_i && (pre_q == PRE_TOP);
  assign load_ok  = load_i
                 && bcd_ok(load_hh_i, 8'h23)
                 && bcd_ok(load_mm_i, 8'h59)
                 && bcd_ok(load_ss_i, 8'h59);

  always_comb begin
    pre_d = pre_q;
    hh_d  = hh_q;
    mm_d  = mm_q;
    ss_d  = ss_q;
    day_d = 1'b0;
    err_d = 1'b0;
    if (ena_i)
      pre_d = sec_tick ? 16'd0 : pre_q + 16'd1;
    if (load_ok) begin
      // a valid load also swallows any coincident second tick
      hh_d  = load_hh_i;
      mm_d  = load_mm_i;
      ss_d  = load_ss_i;
      pre_d = 16'd0;
    end else begin
      err_d = load_i;
      if (sec_tick) begin
        ss_d = inc60(ss_q);
        if (ss_q == 8'h59) begin
          mm_d = inc60(mm_q);
          if (mm_q == 8'h59) begin
            hh_d  = inc24(hh_q);
            day_d = (hh_q == 8'h23);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hh_q  <= RST_HH;
      mm_q  <= 8'h00;
      ss_q  <= 8'h00;
      pre_q <= 16'd0;
      day_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      hh_q  <= hh_d;
      mm_q  <= mm_d;
      ss_q  <= ss_d;
      pre_q <= pre_d;
      day_q <= day_d;
      err_q <= err_d;
    end
  end

  logic [4:0] hbin;
  logic [3:0] h12;
  assign hbin = {1'b0, hh_q[7:4]} * 5'd10
              + {1'b0, hh_q[3:0]};
  assign h12  = 4'(hbin - 5'd12);

  always_comb begin
    hh_o = hh_q;
    pm_o = 1'b0;
    if (!mode_24h_i) begin
      if (hbin == 5'd0) begin
        hh_o = 8'h12;
      end else if (hbin >= 5'd12) begin
        pm_o = 1'b1;
        if (hbin > 5'd12)
          hh_o = (h12 >= 4'd10) ? {4'd1, h12 - 4'd10}
                                : {4'd0, h12};
      end
    end
  end

  assign mm_o       = mm_q;
  assign ss_o       = ss_q;
  assign day_tick_o = day_q;
  assign load_err_o = err_q;

`ifdef BCD_RTC_ALARM_EN
  logic       armed_q, armed_d, ring_q, ring_d;
  logic [7:0] al_hh_q, al_hh_d, al_mm_q, al_mm_d;
  logic       set_ok, al_hit;

  assign set_ok = alarm_set_i
               && bcd_ok(alarm_hh_i, 8'h23)
               && bcd_ok(alarm_mm_i, 8'h59);
  assign al_hit = armed_q && (load_ok || sec_tick)
               && (hh_d == al_hh_q)
               && (mm_d == al_mm_q)
               && (ss_d == 8'h00);

  always_comb begin
    armed_d = armed_q;
    ring_d  = ring_q;
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    if (alarm_ack_i) begin
      armed_d = 1'b0;
      ring_d  = 1'b0;
    end else begin
      if (al_hit)
        ring_d = 1'b1;
      if (set_ok) begin
        armed_d = 1'b1;
        al_hh_d = alarm_hh_i;
        al_mm_d = alarm_mm_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      armed_q <= 1'b0;
      ring_q  <= 1'b0;
      al_hh_q <= 8'h00;
      al_mm_q <= 8'h00;
    end else begin
      armed_q <= armed_d;
      ring_q  <= ring_d;
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
    end
  end

  assign alarm_ring_o = ring_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_set_i, alarm_hh_i,
                          alarm_mm_i, alarm_ack_i};
  assign alarm_ring_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_rtc_sec.sv
// Randomised self-checking bench for bcd_rtc_sec.
// Reference model keeps time as seconds-of-day integers.
module tb_bcd_rtc_sec;

  localparam int         DIV = 4;
  localparam logic [7:0] RST = 8'h00;

  logic       clk = 1'b0;
  logic       reset, ena, mode_24h, load;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh, mm, ss;
  logic       pm, day_tick, load_err;
  logic       alarm_set, alarm_ack, alarm_ring;
  logic [7:0] alarm_hh, alarm_mm;

  int checks = 0;
  int failures = 0;

  int m_sec, m_pre, m_alh, m_alm;
  bit m_dt, m_le, m_armed, m_ring;

  always #5 clk = ~clk;

  bcd_rtc_sec #(.TICK_DIV(DIV), .RST_HH(RST)) dut (
    .clk_i(clk), .reset_i(reset), .ena_i(ena),
    .mode_24h_i(mode_24h), .load_i(load),
    .load_hh_i(load_hh), .load_mm_i(load_mm),
    .load_ss_i(load_ss),
    .hh_o(hh), .mm_o(mm), .ss_o(ss), .pm_o(pm),
    .day_tick_o(day_tick), .load_err_o(load_err),
    .alarm_set_i(alarm_set), .alarm_hh_i(alarm_hh),
    .alarm_mm_i(alarm_mm), .alarm_ack_i(alarm_ack),
    .alarm_ring_o(alarm_ring)
  );

  function automatic int bcd2i(logic [7:0] v);
    return v[7:4] * 10 + v[3:0];
  endfunction

  function automatic bit valid8(logic [7:0] v, int max);
    return v[7:4] <= 9 && v[3:0] <= 9 && bcd2i(v) <= max;
  endfunction

  function automatic logic [7:0] i2bcd(int n);
    return 8'((n / 10) * 16 + n % 10);
  endfunction

  function automatic logic [27:0] actv();
    return {hh, mm, ss, pm, day_tick, load_err, alarm_ring};
  endfunction

  function automatic logic [27:0] expv();
    int h;
    logic [7:0] dh;
    bit p;
    h = m_sec / 3600;
    if (mode_24h) begin
      dh = i2bcd(h);
      p  = 1'b0;
    end else begin
      dh = i2bcd((h % 12 == 0) ? 12 : h % 12);
      p  = (h >= 12);
    end
    return {dh, i2bcd((m_sec / 60) % 60), i2bcd(m_sec % 60),
            p, m_dt, m_le, m_ring};
  endfunction

  // advance model using current inputs, then clock the DUT
  task automatic cyc();
    bit tick, ok, hit;
    int ns;
    if (reset) begin
      m_sec = bcd2i(RST) * 3600;
      m_pre = 0;
      m_dt = 0; m_le = 0; m_armed = 0; m_ring = 0;
    end else begin
      tick = ena && (m_pre == DIV - 1);
      ok = load && valid8(load_hh, 23)
         && valid8(load_mm, 59) && valid8(load_ss, 59);
      ns = m_sec;
      if (ena) m_pre = tick ? 0 : m_pre + 1;
      m_dt = 0;
      if (ok) begin
        ns = bcd2i(load_hh) * 3600 + bcd2i(load_mm) * 60
           + bcd2i(load_ss);
        m_pre = 0;
      end else if (tick) begin
        m_dt = (m_sec == 86399);
        ns = (m_sec + 1) % 86400;
      end
      m_le = load && !ok;
`ifdef BCD_RTC_ALARM_EN
      hit = m_armed && (ok || tick)
         && ns == m_alh * 3600 + m_alm * 60;
      if (alarm_ack) begin
        m_ring = 0;
        m_armed = 0;
      end else begin
        if (hit) m_ring = 1;
        if (alarm_set && valid8(alarm_hh, 23)
            && valid8(alarm_mm, 59)) begin
          m_armed = 1;
          m_alh = bcd2i(alarm_hh);
          m_alm = bcd2i(alarm_mm);
        end
      end
`else
      hit = 0;
`endif
      m_sec = ns;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 0; ena = 0; load = 0;
    alarm_set = 0; alarm_ack = 0;
  endtask

  task automatic do_load(logic [7:0] h, logic [7:0] m,
                         logic [7:0] s);
    load = 1; load_hh = h; load_mm = m; load_ss = s;
    cyc();
    load = 0;
  endtask

  task automatic test_reset();
    quiet();
    mode_24h = 0;
    reset = 1;
    cyc(); cyc();
    reset = 0;
    checks++;
    if (actv() !== {8'h12, 8'h00, 8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h",
               actv(), {8'h12, 8'h00, 8'h00, 4'b0000});
    end
    checks++;
    if (actv() !== expv()) begin
      failures++;
      $display("FAIL reset_model got=%h want=%h",
               actv(), expv());
    end
  endtask

  task automatic test_hour_count();
    quiet();
    mode_24h = 0;
    ena = 1;
    for (int i = 0; i < 3600 * DIV; i++) begin
      cyc();
      if (i % DIV == DIV - 1) begin
        checks++;
        if (actv() !== expv()) begin
          failures++;
          $display("FAIL hour_count@%0d got=%h want=%h",
                   i, actv(), expv());
        end
      end
    end
    ena = 0;
    checks++;
    if ({hh, mm, ss, pm} !== {8'h01, 8'h00, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL hour_final got=%h want=%h",
               {hh, mm, ss, pm}, {8'h01, 8'h00, 8'h00, 1'b0});
    end
  endtask

  task automatic test_prescaler();
    quiet();
    mode_24h = 1;
    do_load(8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      ena = 1; cyc(); ena = 0;
      repeat ($urandom_range(0, 2)) cyc();
    end
    checks++;
    if (ss !== 8'h02 || actv() !== expv()) begin
      failures++;
      $display("FAIL prescale_8 got=%h want=%h",
               actv(), expv());
    end
    repeat (2) begin ena = 1; cyc(); end
    ena = 0;
    do_load(8'h00, 8'h00, 8'h00);
    repeat (3) begin ena = 1; cyc(); end
    ena = 0;
    checks++;
    if (ss !== 8'h00) begin
      failures++;
      $display("FAIL prescale_clr got=%h want=00", ss);
    end
    ena = 1; cyc(); ena = 0;
    checks++;
    if (ss !== 8'h01 || actv() !== expv()) begin
      failures++;
      $display("FAIL prescale_4th got=%h want=%h",
               actv(), expv());
    end
  endtask

  task automatic test_day_rollover();
    logic [8:0] want;
    quiet();
    for (int md = 1; md >= 0; md--) begin
      mode_24h = md[0];
      do_load(8'h23, 8'h59, 8'h59);
      want = md[0] ? {8'h23, 1'b0} : {8'h11, 1'b1};
      checks++;
      if ({hh, pm} !== want) begin
        failures++;
        $display("FAIL day_pre m%0d got=%h want=%h",
                 md, {hh, pm}, want);
      end
      ena = 1;
      for (int i = 0; i < DIV; i++) begin
        cyc();
        checks++;
        if (actv() !== expv()) begin
          failures++;
          $display("FAIL day_step m%0d got=%h want=%h",
                   md, actv(), expv());
        end
      end
      ena = 0;
      want = md[0] ? {8'h00, 1'b0} : {8'h12, 1'b0};
      checks++;
      if ({hh, pm, mm, ss, day_tick} !==
          {want, 8'h00, 8'h00, 1'b1}) begin
        failures++;
        $display("FAIL day_wrap m%0d got=%h want=%h", md,
                 {hh, pm, mm, ss, day_tick},
                 {want, 8'h00, 8'h00, 1'b1});
      end
      cyc();
      checks++;
      if (day_tick !== 1'b0) begin
        failures++;
        $display("FAIL day_pulse m%0d got=%b want=0",
                 md, day_tick);
      end
    end
  endtask

  task automatic test_load_err();
    logic [7:0] bad [2];
    quiet();
    mode_24h = 1;
    bad[0] = 8'h24;
    bad[1] = 8'h1A;
    do_load(8'h05, 8'h06, 8'h07);
    for (int i = 0; i < 2; i++) begin
      do_load(bad[i], 8'h00, 8'h00);
      checks++;
      if ({load_err, hh, mm, ss} !==
          {1'b1, 8'h05, 8'h06, 8'h07}) begin
        failures++;
        $display("FAIL load_bad%0d got=%h want=%h", i,
                 {load_err, hh, mm, ss},
                 {1'b1, 8'h05, 8'h06, 8'h07});
      end
      cyc();
      checks++;
      if (load_err !== 1'b0) begin
        failures++;
        $display("FAIL load_err_pulse%0d got=%b want=0",
                 i, load_err);
      end
    end
    repeat (DIV - 1) begin ena = 1; cyc(); end
    ena = 1;
    do_load(8'h10, 8'h20, 8'h30);
    checks++;
    if ({hh, mm, ss} !== {8'h10, 8'h20, 8'h30}) begin
      failures++;
      $display("FAIL load_vs_tick got=%h want=102030",
               {hh, mm, ss});
    end
    repeat (DIV - 1) cyc();
    checks++;
    if (ss !== 8'h30 || actv() !== expv()) begin
      failures++;
      $display("FAIL load_pre_clr got=%h want=%h",
               actv(), expv());
    end
    cyc();
    ena = 0;
    checks++;
    if (ss !== 8'h31) begin
      failures++;
      $display("FAIL load_then_tick got=%h want=31", ss);
    end
  endtask

  task automatic test_mode_toggle();
    quiet();
    mode_24h = 1;
    do_load(8'h13, 8'h00, 8'h00);
    checks++;
    if ({hh, pm} !== {8'h13, 1'b0}) begin
      failures++;
      $display("FAIL mode24 got=%h want=130", {hh, pm});
    end
    mode_24h = 0;
    #1;
    checks++;
    if ({hh, pm, ss} !== {8'h01, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL mode12 got=%h want=%h",
               {hh, pm, ss}, {8'h01, 1'b1, 8'h00});
    end
    ena = 1;
    repeat (DIV) cyc();
    ena = 0;
    checks++;
    if ({hh, pm, ss} !== {8'h01, 1'b1, 8'h01}) begin
      failures++;
      $display("FAIL mode_count got=%h want=%h",
               {hh, pm, ss}, {8'h01, 1'b1, 8'h01});
    end
    mode_24h = 1;
    #1;
    checks++;
    if (actv() !== expv() || hh !== 8'h13) begin
      failures++;
      $display("FAIL mode_back got=%h want=%h",
               actv(), expv());
    end
  endtask

  task automatic test_alarm();
    bit want;
`ifdef BCD_RTC_ALARM_EN
    want = 1;
`else
    want = 0;
`endif
    quiet();
    mode_24h = 1;
    alarm_ack = 1; cyc(); alarm_ack = 0;
    alarm_set = 1; alarm_hh = 8'h07; alarm_mm = 8'h30;
    cyc();
    alarm_set = 0;
    do_load(8'h07, 8'h29, 8'h59);
    ena = 1;
    repeat (DIV) cyc();
    ena = 0;
    checks++;
    if ({alarm_ring, hh, mm, ss} !==
        {want, 8'h07, 8'h30, 8'h00}) begin
      failures++;
      $display("FAIL alarm_ring got=%h want=%h",
               {alarm_ring, hh, mm, ss},
               {want, 8'h07, 8'h30, 8'h00});
    end
    cyc();
    checks++;
    if (alarm_ring !== want) begin
      failures++;
      $display("FAIL alarm_hold got=%b want=%b",
               alarm_ring, want);
    end
    alarm_ack = 1; cyc(); alarm_ack = 0;
    checks++;
    if (alarm_ring !== 1'b0 || actv() !== expv()) begin
      failures++;
      $display("FAIL alarm_ack got=%h want=%h",
               actv(), expv());
    end
  endtask

  task automatic test_random();
    int t;
    quiet();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom % 997 == 0);
      ena = $urandom % 2;
      load = ($urandom % 16 == 0);
      if ($urandom % 4 == 0) begin
        load_hh = 8'($urandom);
        load_mm = 8'($urandom);
        load_ss = 8'($urandom);
      end else begin
        load_hh = i2bcd(($urandom % 3 == 0) ? 23
                        : $urandom_range(0, 23));
        load_mm = i2bcd($urandom_range(55, 59));
        load_ss = i2bcd($urandom_range(50, 59));
      end
      if ($urandom % 64 == 0) mode_24h = ~mode_24h;
      alarm_set = ($urandom % 32 == 0);
      t = (m_sec / 60 + $urandom_range(0, 1)) % 1440;
      alarm_hh = ($urandom % 8 == 0) ? 8'($urandom)
                                      : i2bcd(t / 60);
      alarm_mm = i2bcd(t % 60);
      alarm_ack = ($urandom % 128 == 0);
      cyc();
      checks++;
      if (actv() !== expv()) begin
        failures++;
        $display("FAIL random@%0d got=%h want=%h",
                 i, actv(), expv());
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    mode_24h = 0;
    load_hh = 0; load_mm = 0; load_ss = 0;
    alarm_hh = 0; alarm_mm = 0;
    m_sec = 0; m_pre = 0; m_alh = 0; m_alm = 0;
    m_dt = 0; m_le = 0; m_armed = 0; m_ring = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_hour_count();
    test_prescaler();
    test_day_rollover();
    test_load_err();
    test_mode_toggle();
    test_alarm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_rtc_sec.md
Name: bcd_rtc_sec

Overview:
Parametrised BCD real-time clock, the successor to the fixed 12-hour hh:mm:ss counter.
- Time is always held internally in 24-hour BCD.
- Display format (12 h with AM/PM, or 24 h) is switchable at run time without disturbing the count.
- Adds a built-in seconds prescaler, validated synchronous time load, a day-rollover strobe and an optional alarm.
- Sits between the timebase strobe generator and the display/driver logic.

Parameters:
TICK_DIV, 1, number of ena pulses per one-second advance (1..65535); 1 = every ena advances.
RST_HH, 8'h00, 24-h BCD hour loaded at reset (must be a valid 00..23 BCD value).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ena  in  1  timebase strobe, one clk wide per pulse
mode_24h  in  1  display format: 1 = 24 h, 0 = 12 h with pm
load  in  1  load strobe for time registers
load_hh  in  8  24-h BCD hour to load
load_mm  in  8  BCD minute to load
load_ss  in  8  BCD second to load
hh  out  8  displayed BCD hour
mm  out  8  BCD minute
ss  out  8  BCD second
pm  out  1  12-h mode PM flag; 0 in 24-h mode
day_tick  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
load_err  out  1  one-cycle pulse, load rejected
alarm_set  in  1  capture alarm_hh/alarm_mm, arm alarm (feature only)
alarm_hh  in  8  24-h BCD alarm hour (feature only)
alarm_mm  in  8  BCD alarm minute (feature only)
alarm_ack  in  1  clears ring and disarms (feature only)
alarm_ring  out  1  alarm active level (feature only)

Behaviour:
- All state updates on posedge clk. Reset is synchronous, active-high, and overrides everything else.
- Reset values: internal time RST_HH:00:00, prescaler 0, day_tick 0, load_err 0, alarm disarmed, alarm_ring 0.
- Prescaler:
  - 16-bit counter advanced by ena.
  - When ena is high and prescaler == TICK_DIV-1: the prescaler returns to 0 and sec_tick is asserted internally for that cycle.
  - sec_tick advances time one second on the same clock edge, so there is zero added latency.
- Cascade: per-digit BCD, same chaining as before.
  - ss low 9->0 carries to ss high; ss high 5->0 carries to mm; mm likewise to hh.
  - Hour wraps 23 -> 00 (BCD 8'h23 -> 8'h00). Digits never hold non-BCD values.
- day_tick: high for exactly the cycle after the edge on which the time moves 23:59:59 -> 00:00:00.
- Load:
  - When load is high, validate: hh <= 8'h23, mm <= 8'h59, ss <= 8'h59, every nibble <= 9.
  - Valid: the time takes the load values on that edge, the prescaler clears to 0, and any same-cycle sec_tick is discarded (load wins).
  - Invalid: time is unchanged, the prescaler advances normally, and load_err is high for the next cycle.
- Display mapping, combinational from the internal time registers:
  - mode_24h = 1: hh = internal hour, pm = 0.
  - mode_24h = 0, internal hour 00: hh = 8'h12, pm = 0.
  - mode_24h = 0, internal hour 01..11: hh unchanged, pm = 0.
  - mode_24h = 0, internal hour 12: hh = 8'h12, pm = 1.
  - mode_24h = 0, internal hour 13..23: hh = hour - 12 in BCD (13->01, 19->07, 20->08, 23->11), pm = 1.
- Toggling mode_24h changes only hh/pm presentation; the counting sequence is identical in both modes.

Optional Feature:
Macro: BCD_RTC_ALARM_EN
- Defined:
  - alarm_set captures alarm_hh/alarm_mm and sets armed, provided the values are valid BCD within 00..23 / 00..59; invalid values are ignored.
  - When armed and a sec_tick or valid load makes the time equal alarm_hh:alarm_mm:00, alarm_ring goes high the next cycle.
  - alarm_ring holds until alarm_ack, which clears ring and armed.
  - alarm_set and alarm_ack in the same cycle: alarm_ack wins.
- Undefined: ports remain, inputs are ignored, alarm_ring is tied 0, and no alarm registers exist.

Test Plan:
- Reset with RST_HH=8'h00, mode_24h=0 -> hh=8'h12, mm=0, ss=0, pm=0; after 3600 sec_ticks -> hh=8'h01, pm=0.
- TICK_DIV=4: 8 ena pulses -> ss=8'h02. Load 00:00:00 after 2 ena pulses, then 3 more ena -> ss still 8'h00 (prescaler cleared); 4th ena -> ss=8'h01.
- Load 8'h23/8'h59/8'h59, one sec_tick -> time 00:00:00, day_tick high exactly one cycle. Same sequence in 12-h mode -> hh 8'h11 pm=1 becomes 8'h12 pm=0.
- Load 8'h24/8'h00/8'h00 and 8'h1A/8'h00/8'h00 -> time unchanged, load_err pulses once each. Load coincident with sec_tick -> the load value wins.
- Internal 8'h13 then toggle mode_24h 1 -> 0 -> hh 8'h13 -> 8'h01, pm 0 -> 1, ss continues counting without a skip.
- BCD_RTC_ALARM_EN: arm 07:30, load 07:29:59, one sec_tick -> alarm_ring=1 the next cycle; alarm_ack -> 0. Repeat without the macro -> alarm_ring stays 0.
